// File: rtl/mdu_pkg.sv
// Shared opcode constants and FSM state type for the sequential multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OpMul   = 3'b000;
    localparam logic [2:0] OpUmull = 3'b001;
    localparam logic [2:0] OpSmull = 3'b010;
    localparam logic [2:0] OpUdiv  = 3'b100;
    localparam logic [2:0] OpSdiv  = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StDone
    } state_e;

    // Signed ops run on magnitudes and get their sign restored afterwards.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OpSmull) || (op == OpSdiv);
    endfunction

endpackage

// File: rtl/mul_div_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle. Divide support is compiled in only when MUL_DIV_SEQ_DIV_EN is
// defined; otherwise UDIV/SDIV opcodes complete immediately as illegal.
module mul_div_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             err
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   One  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] One2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  b_q;
    logic              neg_lo_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              signed_op;
    logic              legal;
    logic              res_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    msum;
    logic [2*WIDTH-1:0] prod_neg;

`ifdef MUL_DIV_SEQ_DIV_EN
    logic              neg_hi_q;
    logic [WIDTH:0]    dshift;
    logic [WIDTH:0]    ddiff;
    logic              dge;
`endif

    // Operand conditioning and per-iteration datapath.
    always_comb begin
        signed_op = op_is_signed(op);
        legal     = (op == OpMul) || (op == OpUmull) || (op == OpSmull);
`ifdef MUL_DIV_SEQ_DIV_EN
        legal     = legal || (op == OpUdiv) || (op == OpSdiv);
`endif
        res_neg   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        a_mag     = (signed_op && a[WIDTH-1]) ? (~a + One) : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? (~b + One) : b;
        // Multiplier sits in lo_q and shifts out LSB-first; multiplicand in b_q.
        msum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        prod_neg  = ~{hi_q, lo_q} + One2;
`ifdef MUL_DIV_SEQ_DIV_EN
        // Dividend shifts out of lo_q MSB-first into the partial remainder.
        dshift    = {hi_q, lo_q[WIDTH-1]};
        ddiff     = dshift - {1'b0, b_q};
        dge       = ~ddiff[WIDTH];
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_lo_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MUL_DIV_SEQ_DIV_EN
            neg_hi_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        err_q  <= 1'b0;
                        op_q   <= op;
                        cnt_q  <= CntW'(WIDTH);
                        busy_q <= 1'b1;
                        if (!legal) begin
                            hi_q    <= '0;
                            lo_q    <= '0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
`ifdef MUL_DIV_SEQ_DIV_EN
                        else if (op[2] && (b == '0)) begin
                            hi_q    <= a;
                            lo_q    <= '1;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (op[2]) begin
                            hi_q     <= '0;
                            lo_q     <= a_mag;
                            b_q      <= b_mag;
                            neg_lo_q <= res_neg;
                            neg_hi_q <= signed_op && a[WIDTH-1];
                            state_q  <= StCalc;
                        end
`endif
                        else begin
                            hi_q     <= '0;
                            lo_q     <= b_mag;
                            b_q      <= a_mag;
                            neg_lo_q <= res_neg;
                            state_q  <= StCalc;
                        end
                    end
                end
                StCalc: begin
`ifdef MUL_DIV_SEQ_DIV_EN
                    if (op_q[2]) begin
                        hi_q <= dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], dge};
                    end else
`endif
                    begin
                        hi_q <= msum[WIDTH:1];
                        lo_q <= {msum[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFixup;
                    end
                end
                StFixup: begin
                    case (op_q)
                        OpMul:   hi_q <= '0;
                        OpSmull: if (neg_lo_q) {hi_q, lo_q} <= prod_neg;
`ifdef MUL_DIV_SEQ_DIV_EN
                        OpSdiv: begin
                            if (neg_lo_q) lo_q <= ~lo_q + One;
                            if (neg_hi_q) hi_q <= ~hi_q + One;
                        end
`endif
                        default: ;
                    endcase
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    // A start seen here is deliberately dropped.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy      = busy_q;
        done      = done_q;
        err       = err_q;
        result_lo = lo_q;
        result_hi = hi_q;
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq (WIDTH=32) with an arithmetic reference model.
// Divide expectations follow MUL_DIV_SEQ_DIV_EN as defined for the build.
module tb_mul_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] cap_lo;
    logic [W-1:0] cap_hi;
    logic         cap_err;
    int           cap_lat;

    mul_div_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the operation definitions.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] lo,
                                  output logic [W-1:0] hi, output logic e);
        logic [63:0] up;
        longint sx, sy, sp, sq, sr;
        bit div_en;
`ifdef MUL_DIV_SEQ_DIV_EN
        div_en = 1'b1;
`else
        div_en = 1'b0;
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        lo = '0; hi = '0; e = 1'b0;
        up = {32'b0, x} * {32'b0, y};
        case (o)
            3'b000: lo = up[31:0];
            3'b001: {hi, lo} = up;
            3'b010: begin sp = sx * sy; {hi, lo} = sp[63:0]; end
            3'b100, 3'b101: begin
                if (!div_en) e = 1'b1;
                else if (y == '0) begin lo = '1; hi = x; e = 1'b1; end
                else if (o == 3'b100) begin lo = x / y; hi = x % y; end
                else begin
                    sq = sx / sy; sr = sx % sy;
                    lo = sq[31:0]; hi = sr[31:0];
                end
            end
            default: e = 1'b1;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation, optionally poke start at label ign while busy, then check.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int ign);
        logic [W-1:0] elo, ehi;
        logic ee;
        int exp_lat;
        bit seen, busy_ok;
        model(o, x, y, elo, ehi, ee);
        exp_lat = ee ? 1 : W + 2;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        seen = 1'b0; busy_ok = 1'b1; cap_lat = 0;
        for (int k = 1; k <= W + 6 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1; cap_lat = k;
                cap_lo = result_lo; cap_hi = result_hi; cap_err = err;
                start = 1'b1; op = 3'b000; a = $urandom; b = $urandom;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (k == ign) begin
                    start = 1'b1; op = 3'b001; a = $urandom; b = $urandom;
                end
            end
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_eq("latency", 64'(cap_lat), 64'(exp_lat));
            check_eq("result_lo", 64'(cap_lo), 64'(elo));
            check_eq("result_hi", 64'(cap_hi), 64'(ehi));
            check_eq("err", 64'(cap_err), 64'(ee));
            check_eq("busy_during", 64'(busy_ok), 64'd1);
            @(negedge clk);
            start = 1'b0;
            check_eq("idle_after_done", {62'b0, busy, done}, 64'd0);
            check_eq("hold_results", {result_hi, result_lo}, {cap_hi, cap_lo});
        end
    endtask

    initial begin
        logic [2:0] op_tab [8];
        op_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        repeat (2) @(negedge clk);
        check_eq("reset_state", {29'b0, busy, done, err, result_hi, result_lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(3'b000, 32'd7, 32'd6, 5);
        check_eq("mul7x6_lo", 64'(cap_lo), 64'h2A);
        check_eq("mul7x6_lat", 64'(cap_lat), 64'd34);
        run_op(3'b001, '1, '1, 0);
        check_eq("umull_hi", 64'(cap_hi), 64'hFFFF_FFFE);
        run_op(3'b010, '1, 32'd2, 0);
        check_eq("smull_lo", 64'(cap_lo), 64'hFFFF_FFFE);
`ifdef MUL_DIV_SEQ_DIV_EN
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 0);
        check_eq("sdiv_q", 64'(cap_lo), 64'hFFFF_FFFD);
        run_op(3'b101, 32'h8000_0000, '1, 0);
        check_eq("sdiv_ovf_q", 64'(cap_lo), 64'h8000_0000);
        run_op(3'b100, 32'h64, '0, 0);
        check_eq("udiv0_hi", 64'(cap_hi), 64'h64);
`else
        run_op(3'b100, 32'd10, 32'd2, 0);
        check_eq("nodiv_err", 64'(cap_err), 64'd1);
`endif
        run_op(3'b011, 32'd3, 32'd4, 0);
        check_eq("illegal_err", 64'(cap_err), 64'd1);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd7; b = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("async_reset", {29'b0, busy, done, err, result_hi, result_lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 60; i++) begin
            run_op(op_tab[$urandom_range(0, 7)], rnd_val(), rnd_val(),
                   int'($urandom_range(0, 40)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width (>=4, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  operation: 000 MUL, 001 UMULL, 010 SMULL, 100 UDIV, 101 SDIV; others illegal.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port busy  output  1  high while not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result_lo  output  WIDTH  product low half / quotient.
REQ-011 SHALL have port result_hi  output  WIDTH  product high half / remainder (0 for MUL).
REQ-012 SHALL have port err  output  1  divide-by-zero or illegal op; valid with done.

Function
REQ-013 SHALL capture a, b and op on the edge where start=1 in IDLE; later input changes have no effect.
REQ-014 SHALL implement states IDLE, CALC, FIXUP, DONE.
REQ-015 SHALL iterate radix-2 shift-add (multiply) or restoring shift-subtract (divide), one bit per cycle, for WIDTH cycles in CALC.
REQ-016 SHALL make signed ops use operand magnitudes in CALC and apply sign correction in FIXUP.
REQ-017 SHALL make the SMULL product sign the XOR of operand signs.
REQ-018 SHALL make the SDIV quotient truncate toward zero, with the remainder taking the dividend's sign.
REQ-019 SHALL give SDIV of most-negative / -1 quotient = most-negative and remainder 0, err=0.
REQ-020 SHALL assert done in DONE, exactly WIDTH+2 edges after the start edge, then return to IDLE.
REQ-021 SHALL hold result_lo/result_hi/err stable from done until the next accepted start.
REQ-022 SHALL make divide by zero go IDLE->DONE, with done on the edge after start, quotient all-ones, remainder = a, err=1.
REQ-023 SHALL make an illegal op go IDLE->DONE with results 0 and err=1.
REQ-024 SHALL ignore start while busy=1; start in the DONE cycle is also ignored.
REQ-025 SHALL clear err on every accepted start.

Reset
REQ-026 SHALL, on reset low, immediately force IDLE, busy=0, done=0, err=0, result_lo=0, result_hi=0, including mid-operation.
REQ-027 SHALL accept no start until the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL compile in divide support when macro MUL_DIV_SEQ_DIV_EN is defined: UDIV/SDIV behave per REQ-015..REQ-022.
REQ-029 SHALL, without MUL_DIV_SEQ_DIV_EN, instantiate no divide datapath and treat op 100/101 as illegal per REQ-023.

Structure
REQ-030 SHALL take opcode constants and the state enum from shared package mdu_pkg.
REQ-031 SHALL be a single module; no sub-module; the iteration counter is sized $clog2(WIDTH+1).

Verification (WIDTH=32)
REQ-032 SHALL cover: MUL a=7, b=6 -> result_lo=0000002A, result_hi=0, done on edge 34 after start, busy high edges 1..33.
REQ-033 SHALL cover: UMULL FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; SMULL FFFFFFFF*00000002 -> hi=FFFFFFFF, lo=FFFFFFFE.
REQ-034 SHALL cover: SDIV FFFFFFF9/00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; SDIV 80000000/FFFFFFFF -> lo=80000000, hi=0, err=0.
REQ-035 SHALL cover: UDIV 00000064/0 -> lo=FFFFFFFF, hi=00000064, err=1, done on edge 1; op=011 -> results 0, err=1.
REQ-036 SHALL cover: second start at edge 5 of a MUL is ignored, first result intact; reset low at edge 10 -> busy=0, outputs 0 immediately.
REQ-037 SHALL cover: build without MUL_DIV_SEQ_DIV_EN, UDIV 10/2 -> err=1, results 0.
